// File: rtl/chipmunk_pkg.sv
// Shared Chipmunk definitions: request opcodes, the stack engine state type
// and the size of a return address in bytes.
package chipmunk_pkg;

  typedef enum logic [1:0] {
    OP_PUSHB = 2'b00,
    OP_POPB  = 2'b01,
    OP_PUSHW = 2'b10,
    OP_POPW  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    XFER0 = 2'b01,
    XFER1 = 2'b10
  } state_e;

  localparam int WORD_BYTES = 2;

endpackage

// File: rtl/chipmunk_stack_engine.sv
// Chipmunk stack engine: empty-descending byte stack in a memory window.
// Single-byte and atomic two-byte pushes/pops, with occupancy checked on
// accept so over/underflow never touches memory.
//
// state | meaning
// IDLE  | ready for a request; rsp_valid pulses here after completion
// XFER0 | first memory byte (push: low byte write, pop: high byte read)
// XFER1 | second memory byte of a word op
module chipmunk_stack_engine
  import chipmunk_pkg::*;
#(
  parameter int                ADDR_W     = 12,
  parameter int                SP_W       = 6,
  parameter logic [ADDR_W-1:0] STACK_BASE = 12'h1C0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_data,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata,
  output logic [SP_W-1:0]   sp,
  output logic [SP_W:0]     count,
  input  logic              clear_fault,
  output logic              fault_overflow,
  output logic              fault_underflow
);

  localparam int DEPTH = 1 << SP_W;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] data_q, data_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [SP_W:0]     count_q, count_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [ADDR_W-1:0] rsp_data_q, rsp_data_d;
  logic              fault_ovf_q, fault_ovf_d;
  logic              fault_unf_q, fault_unf_d;
  logic              new_ovf, new_unf;
  logic              is_push, is_word;
  logic              req_push;
  int                req_bytes;
  logic [SP_W-1:0]   addr_sp;

  assign is_push  = (op_q == OP_PUSHB) || (op_q == OP_PUSHW);
  assign is_word  = (op_q == OP_PUSHW) || (op_q == OP_POPW);
  assign req_push = (req_op == OP_PUSHB) || (req_op == OP_PUSHW);
  assign req_bytes = ((req_op == OP_PUSHW) || (req_op == OP_POPW)) ? WORD_BYTES : 1;

  // Pops pre-increment: the byte being read sits one above the current sp,
  // so the bus address leads sp by one during pop transfers.
  assign addr_sp   = ((state_q != IDLE) && !is_push) ? sp_q + SP_W'(1) : sp_q;
  assign mem_addr  = STACK_BASE | ADDR_W'(addr_sp);
  assign mem_we    = (state_q != IDLE) && is_push;

  // Write byte is derived from state so reset drops it together with mem_we.
  always_comb begin
    mem_wdata = 8'h00;
    if (state_q == XFER0 && is_push)      mem_wdata = data_q[7:0];
    else if (state_q == XFER1 && is_push) mem_wdata = 8'(data_q[ADDR_W-1:8]);
  end

  assign req_ready       = (state_q == IDLE);
  assign rsp_valid       = rsp_valid_q;
  assign rsp_err         = rsp_err_q;
  assign rsp_data        = rsp_data_q;
  assign sp              = sp_q;
  assign count           = count_q;
  assign fault_overflow  = fault_ovf_q;
  assign fault_underflow = fault_unf_q;

  // Next-state, occupancy check, pointer update and response formation.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    data_d      = data_q;
    sp_d        = sp_q;
    count_d     = count_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = rsp_data_q;
    new_ovf     = 1'b0;
    new_unf     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d   = op_e'(req_op);
          data_d = req_data;
          if (req_push && (int'(count_q) + req_bytes > DEPTH)) begin
            new_ovf     = 1'b1;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (!req_push && (int'(count_q) < req_bytes)) begin
            new_unf     = 1'b1;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d = XFER0;
          end
        end
      end

      XFER0: begin
        if (is_push) begin
          sp_d    = sp_q - SP_W'(1);
          count_d = count_q + (SP_W+1)'(1);
        end else begin
          sp_d    = sp_q + SP_W'(1);
          count_d = count_q - (SP_W+1)'(1);
          // Word pops park the high byte in the low bits of the data register.
          if (is_word) data_d[7:0] = mem_rdata;
          else         rsp_data_d  = ADDR_W'(mem_rdata);
        end
        if (is_word) begin
          state_d = XFER1;
        end else begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
        end
      end

      XFER1: begin
        if (is_push) begin
          sp_d    = sp_q - SP_W'(1);
          count_d = count_q + (SP_W+1)'(1);
        end else begin
          sp_d       = sp_q + SP_W'(1);
          count_d    = count_q - (SP_W+1)'(1);
          rsp_data_d = ADDR_W'({data_q[7:0], mem_rdata});
        end
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
      end

      default: state_d = IDLE;
    endcase

    // A fault raised in the same cycle as clear_fault must survive.
    fault_ovf_d = (fault_ovf_q && !clear_fault) || new_ovf;
    fault_unf_d = (fault_unf_q && !clear_fault) || new_unf;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath, pointer, response and sticky fault registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q        <= OP_PUSHB;
      data_q      <= '0;
      sp_q        <= '1;
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      fault_ovf_q <= 1'b0;
      fault_unf_q <= 1'b0;
    end else begin
      op_q        <= op_d;
      data_q      <= data_d;
      sp_q        <= sp_d;
      count_q     <= count_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      fault_ovf_q <= fault_ovf_d;
      fault_unf_q <= fault_unf_d;
    end
  end

endmodule

// File: tb/tb_chipmunk_stack_engine.sv
// Bench for chipmunk_stack_engine: directed boundary scenarios followed by
// random traffic, all checked against a byte-queue model of the stack.
module tb_chipmunk_stack_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [11:0] req_data;
  logic        rsp_valid;
  logic        rsp_err;
  logic [11:0] rsp_data;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic [5:0]  sp;
  logic [6:0]  count;
  logic        clear_fault;
  logic        fault_overflow;
  logic        fault_underflow;

  chipmunk_stack_engine dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .sp(sp), .count(count), .clear_fault(clear_fault),
    .fault_overflow(fault_overflow), .fault_underflow(fault_underflow)
  );

  always #5 clk = ~clk;

  // Bus-side RAM
  logic [7:0] ram [0:4095];
  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: bytes on the stack, top at the back.
  logic [7:0]  stk[$];
  logic [11:0] exp_addr[$];
  logic [7:0]  exp_data[$];
  logic [11:0] last_rsp;
  bit          m_ovf, m_unf;
  int          wr_prev, wr_last;

  function automatic logic [5:0] model_sp();
    return 6'(63 - stk.size());
  endfunction

  // Every write strobe must match the next expected write.
  always @(negedge clk) begin
    if (reset === 1'b1 && mem_we === 1'b1) begin
      if (exp_addr.size() == 0) check("unexpected_write", 1, 0);
      else begin
        check("wr_addr", mem_addr, exp_addr.pop_front());
        check("wr_data", mem_wdata, exp_data.pop_front());
      end
      wr_prev = wr_last;
      wr_last = cyc;
    end
  end

  task automatic model_reset();
    stk.delete();
    exp_addr.delete();
    exp_data.delete();
    last_rsp = 12'h000;
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic expect_push(input logic [7:0] b);
    exp_addr.push_back(12'h1C0 | {6'h00, model_sp()});
    exp_data.push_back(b);
    stk.push_back(b);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_sp"}, sp, model_sp());
    check({tag, "_count"}, count, stk.size());
    check({tag, "_fovf"}, fault_overflow, m_ovf);
    check({tag, "_funf"}, fault_underflow, m_unf);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [11:0] d, input bit clr);
    bit push, rej, novf, nunf;
    int n, lat;
    logic [7:0] hi, lo;
    push = (op[0] == 1'b0);
    n    = op[1] ? 2 : 1;
    novf = push && (stk.size() + n > 64);
    nunf = !push && (stk.size() < n);
    rej  = novf || nunf;
    m_ovf = (m_ovf && !clr) || novf;
    m_unf = (m_unf && !clr) || nunf;
    if (!rej) begin
      if (push) begin
        expect_push(d[7:0]);
        if (n == 2) expect_push({4'h0, d[11:8]});
      end else if (n == 1) begin
        last_rsp = {4'h0, stk.pop_back()};
      end else begin
        hi = stk.pop_back();
        lo = stk.pop_back();
        last_rsp = {hi[3:0], lo};
      end
    end
    @(negedge clk);
    check("ready_before", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_data = d; clear_fault = clr;
    @(negedge clk);
    req_valid = 1'b0; clear_fault = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, rej ? 1 : n + 1);
    check("rsp_err", rsp_err, rej);
    check("rsp_data", rsp_data, last_rsp);
    check("writes_done", exp_addr.size(), 0);
    check_state("op");
  endtask

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    wr_prev = 0; wr_last = 0;
    reset = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_data = 12'h000; clear_fault = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_we", mem_we, 0);
    check("rst_wdata", mem_wdata, 0);
    check_state("rst");
    reset = 1'b1;

    // Word round trip
    run_op(2'b10, 12'hABC, 0);
    check("pushw_sp", sp, 6'h3D);
    run_op(2'b11, 12'h000, 0);
    check("popw_data", rsp_data, 12'hABC);
    check("popw_sp", sp, 6'h3F);

    // Underflow from empty
    do_reset();
    run_op(2'b01, 12'h000, 0);
    check("unf_flag", fault_underflow, 1);

    // Overflow boundary
    do_reset();
    for (int i = 0; i < 63; i++) run_op(2'b00, 12'(i * 7 + 3), 0);
    run_op(2'b10, 12'h123, 0);
    check("ovf_flag", fault_overflow, 1);
    check("ovf_count", count, 63);
    run_op(2'b00, 12'h0EE, 0);
    check("full_count", count, 64);
    check("full_sp", sp, 6'h3F);
    run_op(2'b00, 12'h0DD, 0);
    check("full_rej", rsp_err, 1);

    // Reset during XFER1 of a push word (fault_overflow is set beforehand)
    run_op(2'b01, 12'h000, 0);
    run_op(2'b01, 12'h000, 0);
    expect_push(8'hA7);
    expect_push(8'h05);
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b10; req_data = 12'h5A7;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("xfer1_we", mem_we, 1);
    #1 reset = 1'b0;
    model_reset();
    #1;
    check("async_we", mem_we, 0);
    check("async_ready", req_ready, 1);
    check("async_rsp_valid", rsp_valid, 0);
    check_state("async");
    @(negedge clk);
    reset = 1'b1;

    // Clear and new underflow in the same cycle: set wins
    run_op(2'b01, 12'h000, 1);
    check("setwins", fault_underflow, 1);
    run_op(2'b00, 12'h042, 1);
    check("cleared", fault_underflow, 0);

    // Back-to-back pushes with req_valid held
    do_reset();
    expect_push(8'h11);
    expect_push(8'h22);
    @(negedge clk);
    check("b2b_ready0", req_ready, 1);
    req_valid = 1'b1; req_op = 2'b00; req_data = 12'h011;
    @(negedge clk);
    req_data = 12'h022;
    @(negedge clk);
    check("b2b_rsp1", rsp_valid, 1);
    check("b2b_ready1", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_busy", req_ready, 0);
    @(negedge clk);
    check("b2b_rsp2", rsp_valid, 1);
    check("b2b_gap", wr_last - wr_prev, 2);
    check("b2b_left", exp_addr.size(), 0);
    check_state("b2b");

    // Random traffic with drifting push/pop bias
    for (int i = 0; i < 300; i++) begin
      bit push, bias;
      int r;
      bias = ((i / 50) % 2) == 0;
      r = $urandom_range(0, 99);
      push = bias ? (r < 75) : (r < 25);
      run_op({1'($urandom_range(0, 1)), ~push}, 12'($urandom), ($urandom_range(0, 9) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
